regfile_mp: RTL



---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 52 +++++
 rtl/regfile_mp.sv | 86 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the multi-port register file.
// Used by regfile_mp and regfile_scoreboard.
package regfile_pkg;

   localparam int ADDR_W_DEF    = 5;
   localparam int DATA_W_DEF    = 32;
   localparam int ZERO_REG      = 0;
   localparam int DEBUG_REG_DEF = 10;

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with set-over-clear priority
// and a registered population count of the busy vector.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int AW     = 5,
   parameter int NUM_WR = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 iss_valid_i,
   input  logic [AW-1:0]        iss_addr_i,
   input  logic [NUM_WR-1:0]    wr_en_i,
   input  logic [NUM_WR*AW-1:0] wr_addr_i,
   output logic [(2**AW)-1:0]   busy_o,
   output logic [AW:0]          busy_cnt_o
);

   localparam int DEPTH = 2**AW;

   logic [DEPTH-1:0] busy_q, busy_d;
   logic [AW:0]      cnt_q, cnt_d;

   // Next busy vector: writes clear, issue sets (set wins), r0 never busy.
   always_comb begin
      busy_d = busy_q;
      for (int k = 0; k < NUM_WR; k++) begin
         if (wr_en_i[k]) busy_d[wr_addr_i[k*AW +: AW]] = 1'b0;
      end
      if (iss_valid_i) busy_d[iss_addr_i] = 1'b1;
      busy_d[ZERO_REG] = 1'b0;
      cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
      end
   end

   // Busy bits and their count update on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_o     = busy_q;
   assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with busy scoreboard and hardwired r0.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int ADDRESS_WIDTH = ADDR_W_DEF,
   parameter int DATA_WIDTH    = DATA_W_DEF,
   parameter int NUM_RD        = 2,
   parameter int NUM_WR        = 2,
   parameter int DEBUG_REG     = DEBUG_REG_DEF
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
   output logic [NUM_RD-1:0]               rd_busy,
   input  logic [NUM_WR-1:0]               wr_en,
   input  logic [NUM_WR*ADDRESS_WIDTH-1:0] wr_addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0]    wr_data,
   input  logic                            iss_valid,
   input  logic [ADDRESS_WIDTH-1:0]        iss_addr,
   output logic [ADDRESS_WIDTH:0]          busy_cnt,
   output logic [DATA_WIDTH-1:0]           a0
);

   localparam int AW    = ADDRESS_WIDTH;
   localparam int DW    = DATA_WIDTH;
   localparam int DEPTH = 2**AW;

   logic [DW-1:0]    mem_q [DEPTH];
   logic [DEPTH-1:0] busy;

   regfile_scoreboard #(
      .AW     (AW),
      .NUM_WR (NUM_WR)
   ) u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .iss_valid_i (iss_valid),
      .iss_addr_i  (iss_addr),
      .wr_en_i     (wr_en),
      .wr_addr_i   (wr_addr),
      .busy_o      (busy),
      .busy_cnt_o  (busy_cnt)
   );

   // Storage: later (higher) write port overrides on address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] != AW'(ZERO_REG))) begin
               mem_q[wr_addr[k*AW +: AW]] <= wr_data[k*DW +: DW];
            end
         end
      end
   end

   // Read muxes, with optional forwarding of same-cycle writes.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_data[i*DW +: DW] = mem_q[rd_addr[i*AW +: AW]];
         rd_busy[i]          = busy[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
         for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] == rd_addr[i*AW +: AW])
                && (rd_addr[i*AW +: AW] != AW'(ZERO_REG))) begin
               rd_data[i*DW +: DW] = wr_data[k*DW +: DW];
               if (!(iss_valid && (iss_addr == rd_addr[i*AW +: AW])))
                  rd_busy[i] = 1'b0;
            end
         end
`endif
         if (rd_addr[i*AW +: AW] == AW'(ZERO_REG)) begin
            rd_data[i*DW +: DW] = '0;
            rd_busy[i]          = 1'b0;
         end
      end
   end

   assign a0 = mem_q[DEBUG_REG];

endmodule
